// File: rtl/burrito_pkg.sv
// Shared widths, instruction layout and ALU opcodes for the burrito datapath.
// Also provides the instruction decode and the register bank's reset image.
package burrito_pkg;

    localparam int DATA_W  = 32;
    localparam int IDX_W   = 5;
    localparam int OP_W    = 3;
    localparam int NREGS   = 32;
    localparam int INSTR_W = 3 * IDX_W + OP_W;

    // Instruction field positions (LSB of each field)
    localparam int RS1_LSB = 13;
    localparam int RS2_LSB = 8;
    localparam int RD_LSB  = 3;
    localparam int OP_LSB  = 0;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'b000,
        OP_AND = 3'b001,
        OP_OR  = 3'b010,
        OP_SUB = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101,
        OP_NOR = 3'b110,
        OP_SLL = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic [IDX_W-1:0] rs1;
        logic [IDX_W-1:0] rs2;
        logic [IDX_W-1:0] rd;
        alu_op_e          op;
    } instr_t;

    typedef logic [NREGS-1:0][DATA_W-1:0] bank_t;

    function automatic instr_t decode_instr(input logic [INSTR_W-1:0] ins);
        instr_t d;
        d.rs1 = ins[RS1_LSB +: IDX_W];
        d.rs2 = ins[RS2_LSB +: IDX_W];
        d.rd  = ins[RD_LSB  +: IDX_W];
        d.op  = alu_op_e'(ins[OP_LSB +: OP_W]);
        return d;
    endfunction

    // Each register resets to its own index.
    function automatic bank_t reset_image();
        bank_t img;
        for (int i = 0; i < NREGS; i++) begin
            img[i] = DATA_W'(i);
        end
        return img;
    endfunction

endpackage

// File: rtl/burrito_alu.sv
// Purely combinational 32-bit ALU; all arithmetic wraps modulo 2^32.
module burrito_alu
    import burrito_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_e           op,
    output logic [DATA_W-1:0] y
);

    logic slt;

    always_comb begin
        slt = ($signed(a) < $signed(b));
        y   = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_SUB:  y = a - b;
            OP_XOR:  y = a ^ b;
            OP_SLT:  y = {{(DATA_W-1){1'b0}}, slt};
            OP_NOR:  y = ~(a | b);
            // Only the low five bits of b form the shift amount
            OP_SLL:  y = a << b[IDX_W-1:0];
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/burrito.sv
// Single-cycle register bank plus ALU: reads two operands, computes combinationally,
// and writes the result back to rd on every rising clock edge.
module burrito
    import burrito_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instruccion,
    output logic [DATA_W-1:0]  Resultado
);

    instr_t             dec;
    bank_t              regs_q;
    bank_t              regs_d;
    logic [DATA_W-1:0]  opa;
    logic [DATA_W-1:0]  opb;

    assign dec = decode_instr(instruccion);
    assign opa = regs_q[dec.rs1];
    assign opb = regs_q[dec.rs2];

    burrito_alu u_alu (
        .a  (opa),
        .b  (opb),
        .op (dec.op),
        .y  (Resultado)
    );

    // No write enable: rd is overwritten every cycle, including R[0]
    always_comb begin
        regs_d         = regs_q;
        regs_d[dec.rd] = Resultado;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q <= reset_image();
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: tb/tb_burrito.sv
// Directed scoreboard bench for burrito: expected results are queued when an
// instruction is driven and popped when Resultado is sampled.
module tb_burrito;
    import burrito_pkg::*;

    logic               clk;
    logic               reset;
    logic [INSTR_W-1:0] instruccion;
    logic [DATA_W-1:0]  Resultado;

    logic [DATA_W-1:0]  sb[$];
    int                 n_assert = 0;
    int                 n_fail   = 0;

    burrito dut (
        .clk         (clk),
        .reset       (reset),
        .instruccion (instruccion),
        .Resultado   (Resultado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [INSTR_W-1:0] mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                             input logic [4:0] rd, input alu_op_e op);
        return {rs1, rs2, rd, op};
    endfunction

    task automatic expect_val(input logic [DATA_W-1:0] e);
        sb.push_back(e);
    endtask

    task automatic check(input string tag);
        logic [DATA_W-1:0] e;
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL %s: scoreboard empty, observed %h", tag, Resultado);
        end else begin
            e = sb.pop_front();
            assert (Resultado === e) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", tag, Resultado, e);
            end
        end
    endtask

    // Drive one instruction, check it mid-cycle, let one rising edge commit it.
    task automatic step(input logic [INSTR_W-1:0] ins, input logic [DATA_W-1:0] e,
                        input string tag);
        instruccion = ins;
        expect_val(e);
        #1;
        check(tag);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        instruccion = mk(5'd0, 5'd1, 5'd2, OP_ADD);
        #3;
        expect_val(32'd1);
        check("reset_add_0_1");
        instruccion = mk(5'd17, 5'd0, 5'd0, OP_OR);
        #1;
        expect_val(32'd17);
        check("reset_image_r17");
        instruccion = mk(5'd0, 5'd1, 5'd2, OP_ADD);
        @(negedge clk);
        reset = 1'b0;

        // Basic write-back
        step(mk(5'd0, 5'd1, 5'd2, OP_ADD), 32'd1, "add_0_1");
        step(mk(5'd2, 5'd2, 5'd13, OP_AND), 32'd1, "and_r2_written");
        step(mk(5'd3, 5'd4, 5'd5, OP_AND), 32'd0, "and_3_4");
        step(mk(5'd6, 5'd7, 5'd8, OP_OR), 32'd7, "or_6_7");
        step(mk(5'd8, 5'd0, 5'd9, OP_ADD), 32'd7, "add_r8_written");

        // Sub wrap, signed compare, xor, shift with oversized B
        do_reset();
        step(mk(5'd1, 5'd2, 5'd10, OP_SUB), 32'hFFFF_FFFF, "sub_wrap");
        step(mk(5'd1, 5'd2, 5'd14, OP_SLT), 32'd1, "slt_1_2");
        step(mk(5'd2, 5'd1, 5'd15, OP_SLT), 32'd0, "slt_2_1");
        step(mk(5'd10, 5'd1, 5'd16, OP_SLT), 32'd1, "slt_neg1_1_signed");
        step(mk(5'd3, 5'd5, 5'd17, OP_XOR), 32'd6, "xor_3_5");
        step(mk(5'd1, 5'd10, 5'd18, OP_SLL), 32'h8000_0000, "sll_b_low5");
        step(mk(5'd10, 5'd1, 5'd19, OP_ADD), 32'd0, "add_wrap");

        // Repeated self-accumulation, shift, nor
        do_reset();
        step(mk(5'd31, 5'd31, 5'd31, OP_ADD), 32'd62, "add31_first");
        step(mk(5'd31, 5'd31, 5'd31, OP_ADD), 32'd124, "add31_second");
        step(mk(5'd1, 5'd5, 5'd11, OP_SLL), 32'd32, "sll_1_5");
        step(mk(5'd0, 5'd0, 5'd12, OP_NOR), 32'hFFFF_FFFF, "nor_0_0");
        step(mk(5'd1, 5'd1, 5'd0, OP_ADD), 32'd2, "write_r0");
        step(mk(5'd0, 5'd0, 5'd21, OP_ADD), 32'd4, "r0_not_hardwired");

        // Self-reference: read-before-write, then new operand after the edge
        do_reset();
        instruccion = mk(5'd4, 5'd4, 5'd4, OP_ADD);
        expect_val(32'd8);
        #1;
        check("selfref_pre_edge");
        @(posedge clk);
        #2;
        expect_val(32'd16);
        check("selfref_post_edge");
        @(negedge clk);

        // Mid-operation asynchronous reset
        do_reset();
        step(mk(5'd6, 5'd7, 5'd8, OP_OR), 32'd7, "mid_or_6_7");
        instruccion = mk(5'd8, 5'd0, 5'd20, OP_ADD);
        expect_val(32'd7);
        #1;
        check("mid_r8_before_reset");
        reset = 1'b1;
        #1;
        expect_val(32'd8);
        check("async_reset_r8");
        instruccion = mk(5'd8, 5'd8, 5'd8, OP_ADD);
        expect_val(32'd16);
        #1;
        check("reset_held_pre");
        @(posedge clk);
        @(posedge clk);
        #2;
        expect_val(32'd16);
        check("no_write_in_reset");
        @(negedge clk);
        reset = 1'b0;
        #1;
        expect_val(32'd16);
        check("after_release_pre_edge");
        @(posedge clk);
        #2;
        expect_val(32'd32);
        check("first_write_after_release");
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
